// File: rtl/multi_channel_capture.sv
// rtl/multi_channel_capture.sv - burst capture of NUM_CH ADC channels, drained as a ready/valid beat stream
//
// Captures DEPTH samples per channel after a start pulse, then streams them
// channel by channel, sample by sample, MSB slice first.
// Optional feature macro: MULTI_CHANNEL_CAPTURE_TAG_EN (one channel-index tag
// beat ahead of each channel's data).
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   start      capture request pulse (ignored while busy)
//   din        NUM_CH samples, channel c at [c*SAMPLE_W +: SAMPLE_W]
//   din_valid  qualifies all channels of din
//   out_data   output beat
//   out_valid  out_data valid
//   out_ready  downstream accepts the beat
//   out_last   final beat of the burst
//   busy       state is not IDLE
//   state      IDLE=0, CAPTURE=1, DRAIN=2
module multi_channel_capture #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 16,
  parameter int OUT_W    = 8,
  parameter int DEPTH    = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_CH*SAMPLE_W-1:0] din,
  input  logic                       din_valid,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic [1:0]                 state
);

  localparam int BEATS  = SAMPLE_W / OUT_W;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
`ifdef MULTI_CHANNEL_CAPTURE_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Capture side
  logic [IDX_W-1:0] wr_ptr;
  logic             wr_en, wr_last;

  // Read side: fetch pointer plus the read currently returning from the RAM
  logic [IDX_W-1:0]    rd_idx;
  logic [CH_W-1:0]     rd_ch;
  logic                rd_done, rd_en;
  logic                rf, rf_first, rf_last;
  logic [CH_W-1:0]     rf_ch;
  logic [SAMPLE_W-1:0] rd_q [NUM_CH];
  logic [SAMPLE_W-1:0] rd_sel;
  logic [SAMPLE_W-1:0] mem [NUM_CH][DEPTH];

  // Output stage: q0 is the sample being serialised, q1 a one-deep prefetch slot
  logic                v0, v1, f0, f1, l0, l1;
  logic [SAMPLE_W-1:0] d0, d1;
  logic [CH_W-1:0]     c0, c1;
  logic [BEAT_W-1:0]   beat;
  logic                n_v0, n_v1, n_f0, n_f1, n_l0, n_l1;
  logic [SAMPLE_W-1:0] n_d0, n_d1;
  logic [CH_W-1:0]     n_c0, n_c1;
  logic [BEAT_W-1:0]   n_beat;
  logic                tag_ph, beat_end, xfer, pop, final_xfer;
  logic [1:0]          occ;
  logic [SAMPLE_W-1:0] d0_sh;

  assign wr_en   = (state_q == S_CAPTURE) && din_valid;
  assign wr_last = wr_en && (wr_ptr == IDX_W'(DEPTH - 1));

  // A tag beat is pending while f0 is set on a channel's first sample
  assign tag_ph     = TAG_EN && f0;
  assign beat_end   = (beat == BEAT_W'(BEATS - 1));
  assign xfer       = v0 && out_ready;
  assign pop        = xfer && !tag_ph && beat_end;
  assign final_xfer = pop && l0;

  // Issue a read only while the buffered plus in-flight samples, after this
  // cycle's pop, leave room; this gives back-to-back beats even when BEATS=1.
  assign occ   = {1'b0, v0} + {1'b0, v1} + {1'b0, rf};
  assign rd_en = (state_q == S_DRAIN) && !rd_done &&
                 ((occ < 2'd2) || ((occ == 2'd2) && pop));

  assign rd_sel = rd_q[rf_ch];
  assign d0_sh  = d0 << (32'(beat) * OUT_W);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start)      state_d = S_CAPTURE;
      S_CAPTURE: if (wr_last)    state_d = S_DRAIN;
      S_DRAIN:   if (final_xfer) state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    state     = state_q;
    busy      = (state_q != S_IDLE);
    out_valid = v0;
    out_last  = v0 && l0 && !tag_ph && beat_end;
    out_data  = tag_ph ? OUT_W'(c0) : d0_sh[SAMPLE_W-1 -: OUT_W];
  end

  // Write pointer wraps to 0 naturally on the DEPTH-th sample
  always_ff @(posedge clk) begin
    if (rst)        wr_ptr <= '0;
    else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
  end

  // Per-channel sample RAMs, registered read
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en) mem[c][wr_ptr] <= din[c*SAMPLE_W +: SAMPLE_W];
      if (rd_en) rd_q[c] <= mem[c][rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state_q == S_IDLE) begin
      rd_idx   <= '0;
      rd_ch    <= '0;
      rd_done  <= 1'b0;
      rf       <= 1'b0;
      rf_ch    <= '0;
      rf_first <= 1'b0;
      rf_last  <= 1'b0;
    end else begin
      rf <= rd_en;
      if (rd_en) begin
        rf_ch    <= rd_ch;
        rf_first <= (rd_idx == '0);
        rf_last  <= (rd_ch == CH_W'(NUM_CH - 1)) && (rd_idx == IDX_W'(DEPTH - 1));
        rd_idx   <= rd_idx + 1'b1;
        if (rd_idx == IDX_W'(DEPTH - 1)) begin
          rd_ch <= rd_ch + 1'b1;
          if (rd_ch == CH_W'(NUM_CH - 1)) rd_done <= 1'b1;
        end
      end
    end
  end

  // Output stage: retire beats, slide q1 into q0, then land the RAM return
  always_comb begin
    n_v0 = v0; n_d0 = d0; n_f0 = f0; n_l0 = l0; n_c0 = c0; n_beat = beat;
    n_v1 = v1; n_d1 = d1; n_f1 = f1; n_l1 = l1; n_c1 = c1;
    if (xfer) begin
      if (tag_ph) begin
        n_f0 = 1'b0;
      end else if (beat_end) begin
        n_v0   = 1'b0;
        n_beat = '0;
      end else begin
        n_beat = beat + 1'b1;
      end
    end
    if (!n_v0 && n_v1) begin
      n_v0 = 1'b1; n_d0 = d1; n_f0 = f1; n_l0 = l1; n_c0 = c1;
      n_v1 = 1'b0;
    end
    if (rf) begin
      if (!n_v0) begin
        n_v0 = 1'b1; n_d0 = rd_sel; n_f0 = rf_first; n_l0 = rf_last; n_c0 = rf_ch;
      end else begin
        n_v1 = 1'b1; n_d1 = rd_sel; n_f1 = rf_first; n_l1 = rf_last; n_c1 = rf_ch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0 <= 1'b0; d0 <= '0; f0 <= 1'b0; l0 <= 1'b0; c0 <= '0; beat <= '0;
      v1 <= 1'b0; d1 <= '0; f1 <= 1'b0; l1 <= 1'b0; c1 <= '0;
    end else begin
      v0 <= n_v0; d0 <= n_d0; f0 <= n_f0; l0 <= n_l0; c0 <= n_c0; beat <= n_beat;
      v1 <= n_v1; d1 <= n_d1; f1 <= n_f1; l1 <= n_l1; c1 <= n_c1;
    end
  end

endmodule
